// File: rtl/counter_ctrl.sv
// counter_ctrl: command-driven WIDTH-bit counter with terminal compare, one-shot/auto-reload and prescaler.
// Optional down counting is enabled by defining COUNTER_CTRL_DOWN_EN (adds the cmd_dir port).
module counter_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_load,
    input  logic [WIDTH-1:0] cmd_term,
    input  logic             cmd_reload,
`ifdef COUNTER_CTRL_DOWN_EN
    input  logic             cmd_dir,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [1:0] OP_START  = 2'b00;
    localparam logic [1:0] OP_STOP   = 2'b01;
    localparam logic [1:0] OP_RESUME = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    // Prescaler spans 0 .. PRESCALE-1; PRESCALE is limited to 1 .. 2^16 so 16 bits suffice.
    localparam int             PS_W    = 16;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0] PS_ONE  = {{(PS_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             reload_q, reload_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef COUNTER_CTRL_DOWN_EN
    logic             dir_q, dir_d;
`endif

    logic             accept_s;
    logic             tick_s;
    logic             term_hit_s;
    logic [WIDTH-1:0] count_step_s;

    assign accept_s   = cmd_valid && ready_q;
    assign tick_s     = (state_q == ST_RUN) && (ps_q == PS_LAST);
    assign term_hit_s = (count_q == term_q);

`ifdef COUNTER_CTRL_DOWN_EN
    assign count_step_s = dir_q ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
`else
    assign count_step_s = count_q + CNT_ONE;
`endif

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            load_q   <= '0;
            term_q   <= '0;
            reload_q <= 1'b0;
            ps_q     <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef COUNTER_CTRL_DOWN_EN
            dir_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            load_q   <= load_d;
            term_q   <= term_d;
            reload_q <= reload_d;
            ps_q     <= ps_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef COUNTER_CTRL_DOWN_EN
            dir_q    <= dir_d;
`endif
        end
    end

    // Next-state logic: an accepted command always overrides a same-edge tick.
    always_comb begin
        state_d = state_q;
        if (accept_s) begin
            case (cmd_op)
                OP_START:  state_d = ST_RUN;
                OP_STOP: begin
                    if (state_q == ST_RUN) state_d = ST_PAUSE;
                    else                   state_d = state_q;
                end
                OP_RESUME: begin
                    if (state_q == ST_PAUSE) state_d = ST_RUN;
                    else                     state_d = state_q;
                end
                OP_CLEAR:  state_d = ST_IDLE;
                default:   state_d = state_q;
            endcase
        end else if (tick_s && term_hit_s && !reload_q) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    // Count, prescaler and latched START parameters.
    always_comb begin
        count_d  = count_q;
        load_d   = load_q;
        term_d   = term_q;
        reload_d = reload_q;
        ps_d     = ps_q;
`ifdef COUNTER_CTRL_DOWN_EN
        dir_d    = dir_q;
`endif
        if (accept_s) begin
            case (cmd_op)
                OP_START: begin
                    count_d  = cmd_load;
                    load_d   = cmd_load;
                    term_d   = cmd_term;
                    reload_d = cmd_reload;
                    ps_d     = '0;
`ifdef COUNTER_CTRL_DOWN_EN
                    dir_d    = cmd_dir;
`endif
                end
                OP_CLEAR: begin
                    count_d = '0;
                    ps_d    = '0;
                end
                default: begin
                    count_d = count_q;
                    ps_d    = ps_q;
                end
            endcase
        end else if (state_q == ST_RUN) begin
            if (ps_q == PS_LAST) begin
                ps_d = '0;
                if (term_hit_s) begin
                    if (reload_q) count_d = load_q;
                    else          count_d = count_q;
                end else begin
                    count_d = count_step_s;
                end
            end else begin
                ps_d = ps_q + PS_ONE;
            end
        end else begin
            count_d = count_q;
            ps_d    = ps_q;
        end
    end

    // Registered handshake and status outputs.
    always_comb begin
        ready_d = !accept_s;
        done_d  = !accept_s && tick_s && term_hit_s;
        busy_d  = (state_d != ST_IDLE);
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
